// File: rtl/axi_strb_fifo_pkg.sv
// Shared types and width helpers for the AXI write-data strobe FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axi_strb_fifo_pkg;

    // Prefetch state of the first-word-fall-through output register.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_VALID = 2'd2
    } fifo_state_e;

    // One strobe bit per data byte.
    function automatic int strb_w(input int dwidth);
        return dwidth / 8;
    endfunction

    // Stored word is {strobes, data}.
    function automatic int word_w(input int dwidth);
        return dwidth + strb_w(dwidth);
    endfunction

endpackage

// File: rtl/axi_strb_fifo_ram.sv
// Single-clock simple dual-port LSRAM: one write port, one read port with registered address.
// Latency: read data appears the cycle after re_i is sampled with raddr_i.
// Backpressure: none; callers never read and write the same live address.
// Ports: clk_i clock; we_i/waddr_i/wdata_i write port; re_i/raddr_i read request; rdata_o read data.
module axi_strb_fifo_ram
    import axi_strb_fifo_pkg::*;
#(
    parameter int AWIDTH = 4,
    parameter int WIDTH  = word_w(64)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    (* syn_ramstyle = "lsram" *)
    logic [WIDTH-1:0]  mem_q [2**AWIDTH];
    logic [AWIDTH-1:0] raddr_q;

    // Storage is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            raddr_q <= raddr_i;
        end
    end

    assign rdata_o = mem_q[raddr_q];

endmodule

// File: rtl/axi_strb_sync_fifo.sv
// Single-clock FIFO of AXI write beats {strb, data} with count, almost flags and FWFT/standard read.
// Latency: FWFT=1 head visible two edges after a write to an empty FIFO; FWFT=0 data the cycle after an accepted pop.
// Backpressure: push refused while full (overflow pulse), pop refused while empty (underflow pulse).
// Ports: CLK/RESETN; wrEn/wrData/wrStrb push; rdEn pop; rdData/rdStrb/rdValid head; full/empty/almostFull/almostEmpty/count status; overflow/underflow error pulses.
module axi_strb_sync_fifo
    import axi_strb_fifo_pkg::*;
#(
    parameter int AXI_DWIDTH    = 64,
    parameter int FIFO_AWIDTH   = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 1
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic                    wrEn,
    input  logic [AXI_DWIDTH-1:0]   wrData,
    input  logic [AXI_DWIDTH/8-1:0] wrStrb,
    input  logic                    rdEn,
    output logic [AXI_DWIDTH-1:0]   rdData,
    output logic [AXI_DWIDTH/8-1:0] rdStrb,
    output logic                    rdValid,
    output logic                    full,
    output logic                    empty,
    output logic                    almostFull,
    output logic                    almostEmpty,
    output logic [FIFO_AWIDTH:0]    count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int WW = word_w(AXI_DWIDTH);

    typedef logic [FIFO_AWIDTH:0] cnt_t;
    localparam cnt_t DEPTH_C  = cnt_t'(2**FIFO_AWIDTH);
    localparam cnt_t AFULL_C  = cnt_t'(AFULL_THRESH);
    localparam cnt_t AEMPTY_C = cnt_t'(AEMPTY_THRESH);

    fifo_state_e   state_q, state_d;
    cnt_t          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic          inflight_q, inflight_d;
    logic          skid_vld_q, skid_vld_d;
    logic [WW-1:0] skid_q, skid_d, out_q, out_d;
    logic          afull_q, aempty_q, ovf_q, udf_q;

    logic [WW-1:0] ram_q;
    logic          full_w, empty_w, push, pop, rd_issue, out_vld, out_vld_d;
    cnt_t          ram_cnt;
    logic [1:0]    nbuf, nbuf_after;

    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (FWFT != 0) ? (state_q != S_VALID) : (count_q == '0);
    assign push    = wrEn && !full_w;
    assign pop     = rdEn && !empty_w;

    // Pointers carry one extra bit so their difference is the RAM occupancy.
    assign ram_cnt = wr_ptr_q - rd_ptr_q;

    // Words already pulled out of the RAM: output register, skid, read in flight.
    // Keeping this at most two after each edge guarantees every in-flight
    // word has a landing slot, which is what lets pops run every cycle.
    assign out_vld    = (state_q == S_VALID);
    assign nbuf       = 2'(out_vld) + 2'(skid_vld_q) + 2'(inflight_q);
    assign nbuf_after = nbuf - 2'(pop);
    assign rd_issue   = (FWFT != 0) ? ((ram_cnt != '0) && !nbuf_after[1]) : pop;

    axi_strb_fifo_ram #(
        .AWIDTH (FIFO_AWIDTH),
        .WIDTH  (WW)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (push),
        .waddr_i (wr_ptr_q[FIFO_AWIDTH-1:0]),
        .wdata_i ({wrStrb, wrData}),
        .re_i    (rd_issue),
        .raddr_i (rd_ptr_q[FIFO_AWIDTH-1:0]),
        .rdata_o (ram_q)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q + cnt_t'(push);
        rd_ptr_d   = rd_ptr_q + cnt_t'(rd_issue);
        count_d    = count_q + cnt_t'(push) - cnt_t'(pop);
        inflight_d = rd_issue;
        out_d      = out_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        out_vld_d  = out_vld;
        state_d    = state_q;
        if (FWFT != 0) begin
            // Ordered pipeline is out -> skid -> RAM read; a pop drops the
            // head and the remaining words repack toward the output.
            if (pop) begin
                out_vld_d = skid_vld_q | inflight_q;
                if (skid_vld_q) begin
                    out_d      = skid_q;
                    skid_d     = ram_q;
                    skid_vld_d = inflight_q;
                end else if (inflight_q) begin
                    out_d = ram_q;
                end
            end else if (inflight_q) begin
                if (out_vld) begin
                    skid_d     = ram_q;
                    skid_vld_d = 1'b1;
                end else begin
                    out_d     = ram_q;
                    out_vld_d = 1'b1;
                end
            end
            // LOAD is "output empty but a RAM read is on its way".
            if (out_vld_d) begin
                state_d = S_VALID;
            end else if (rd_issue) begin
                state_d = S_LOAD;
            end else begin
                state_d = S_EMPTY;
            end
        end else if (inflight_q) begin
            // Standard mode: remember the last popped word so rdData holds.
            out_d = ram_q;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= S_EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
            out_q      <= '0;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            skid_vld_q <= skid_vld_d;
            skid_q     <= skid_d;
            out_q      <= out_d;
            afull_q    <= (count_d >= AFULL_C);
            aempty_q   <= (count_d <= AEMPTY_C);
            ovf_q      <= wrEn && full_w;
            udf_q      <= rdEn && empty_w;
        end
    end

    // Standard mode shows the RAM word directly in the cycle after the pop.
    logic [WW-1:0] head_w;
    assign head_w = ((FWFT == 0) && inflight_q) ? ram_q : out_q;

    assign rdData      = head_w[AXI_DWIDTH-1:0];
    assign rdStrb      = head_w[WW-1:AXI_DWIDTH];
    assign rdValid     = (FWFT != 0) ? !empty_w : inflight_q;
    assign full        = full_w;
    assign empty       = empty_w;
    assign almostFull  = afull_q;
    assign almostEmpty = aempty_q;
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

endmodule

// File: tb/tb_axi_strb_sync_fifo.sv
// Bench for axi_strb_sync_fifo: FWFT instance against a queue model, standard-mode instance against a vector table.
// Latency: inputs driven at negedge, outputs sampled at the following negedge.
// Backpressure: pops are only counted as accepted when the FIFO reports non-empty.
module tb_axi_strb_sync_fifo;

    logic CLK = 1'b0;
    logic RESETN;
    always #5 CLK = ~CLK;

    // FWFT instance
    logic        wr1, rd1, rv1, full1, empty1, af1, ae1, of1, uf1;
    logic [63:0] wd1, rdat1;
    logic [7:0]  ws1, rstb1;
    logic [4:0]  cnt1;
    // standard-read instance
    logic        wr0, rd0, rv0, full0, empty0, af0, ae0, of0, uf0;
    logic [63:0] wd0, rdat0;
    logic [7:0]  ws0, rstb0;
    logic [4:0]  cnt0;

    axi_strb_sync_fifo #(.AXI_DWIDTH(64), .FIFO_AWIDTH(4), .AFULL_THRESH(12),
                         .AEMPTY_THRESH(2), .FWFT(1)) u_fwft (
        .CLK(CLK), .RESETN(RESETN), .wrEn(wr1), .wrData(wd1), .wrStrb(ws1), .rdEn(rd1),
        .rdData(rdat1), .rdStrb(rstb1), .rdValid(rv1), .full(full1), .empty(empty1),
        .almostFull(af1), .almostEmpty(ae1), .count(cnt1), .overflow(of1), .underflow(uf1));

    axi_strb_sync_fifo #(.AXI_DWIDTH(64), .FIFO_AWIDTH(4), .AFULL_THRESH(12),
                         .AEMPTY_THRESH(2), .FWFT(0)) u_std (
        .CLK(CLK), .RESETN(RESETN), .wrEn(wr0), .wrData(wd0), .wrStrb(ws0), .rdEn(rd0),
        .rdData(rdat0), .rdStrb(rstb0), .rdValid(rv0), .full(full0), .empty(empty0),
        .almostFull(af0), .almostEmpty(ae0), .count(cnt0), .overflow(of0), .underflow(uf0));

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: ordered list of stored beats with the edge they were written on.
    typedef struct {
        logic [63:0] d;
        logic [7:0]  s;
        int          t;
    } ent_t;
    ent_t mq[$];

    // One clock of the FWFT instance, called at a negedge.
    task automatic step1(input logic w, input logic [63:0] d, input logic [7:0] s, input logic r);
        logic was_full, was_empty, push_ok, pop_ok;
        ent_t e;
        was_full  = (mq.size() == 16);
        was_empty = empty1;
        push_ok   = w && !was_full;
        pop_ok    = r && !was_empty;
        if (!was_empty) begin
            if (mq.size() == 0) begin
                chk("head_exists", 64'(mq.size()), 64'd1);
            end else begin
                chk("head_data", rdat1, mq[0].d);
                chk("head_strb", 64'(rstb1), 64'(mq[0].s));
            end
        end
        wr1 = w; wd1 = d; ws1 = s; rd1 = r;
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        wr1 = 1'b0; rd1 = 1'b0;
        if (pop_ok && mq.size() > 0) void'(mq.pop_front());
        if (push_ok) begin
            e.d = d; e.s = s; e.t = cyc;
            mq.push_back(e);
        end
        chk("count", 64'(cnt1), 64'(mq.size()));
        chk("full", 64'(full1), 64'(mq.size() == 16));
        chk("almostFull", 64'(af1), 64'(mq.size() >= 12));
        chk("almostEmpty", 64'(ae1), 64'(mq.size() <= 2));
        chk("overflow", 64'(of1), 64'(w && was_full));
        chk("underflow", 64'(uf1), 64'(r && was_empty));
        chk("rdValid_tie", 64'(rv1), 64'(!empty1));
        // A beat written at edge N must be at the head after edge N+2 at the latest.
        if (mq.size() == 0) chk("empty_model_empty", 64'(empty1), 64'd1);
        else if (cyc - mq[0].t >= 2) chk("head_visible", 64'(empty1), 64'd0);
    endtask

    // Standard-read vectors.
    typedef struct {
        logic        wr, rd;
        logic [63:0] d;
        logic [7:0]  s;
        logic [4:0]  e_cnt;
        logic        e_empty, e_rv, e_uf, e_ae;
        logic [63:0] e_dat;
        logic [7:0]  e_strb;
    } vec_t;

    function automatic vec_t mk(input bit wr, input bit rd, input logic [63:0] d, input logic [7:0] s,
                                input int cnt, input bit em, input bit rv, input bit uf, input bit ae,
                                input logic [63:0] ed, input logic [7:0] es);
        vec_t v;
        v.wr = wr; v.rd = rd; v.d = d; v.s = s; v.e_cnt = 5'(cnt);
        v.e_empty = em; v.e_rv = rv; v.e_uf = uf; v.e_ae = ae; v.e_dat = ed; v.e_strb = es;
        return v;
    endfunction

    vec_t tbl[11];

    initial begin
        tbl[0]  = mk(0, 1, 64'h0,    8'h00, 0, 1, 0, 1, 1, 64'h0,    8'h00);
        tbl[1]  = mk(1, 0, 64'hDEAD, 8'h0F, 1, 0, 0, 0, 1, 64'h0,    8'h00);
        tbl[2]  = mk(1, 0, 64'hBEEF, 8'hF0, 2, 0, 0, 0, 1, 64'h0,    8'h00);
        tbl[3]  = mk(1, 0, 64'h1234, 8'hFF, 3, 0, 0, 0, 0, 64'h0,    8'h00);
        tbl[4]  = mk(0, 1, 64'h0,    8'h00, 2, 0, 1, 0, 1, 64'hDEAD, 8'h0F);
        tbl[5]  = mk(0, 0, 64'h0,    8'h00, 2, 0, 0, 0, 1, 64'hDEAD, 8'h0F);
        tbl[6]  = mk(1, 1, 64'h5555, 8'h33, 2, 0, 1, 0, 1, 64'hBEEF, 8'hF0);
        tbl[7]  = mk(0, 1, 64'h0,    8'h00, 1, 0, 1, 0, 1, 64'h1234, 8'hFF);
        tbl[8]  = mk(0, 1, 64'h0,    8'h00, 0, 1, 1, 0, 1, 64'h5555, 8'h33);
        tbl[9]  = mk(0, 1, 64'h0,    8'h00, 0, 1, 0, 1, 1, 64'h5555, 8'h33);
        tbl[10] = mk(0, 0, 64'h0,    8'h00, 0, 1, 0, 0, 1, 64'h5555, 8'h33);

        RESETN = 1'b0;
        wr1 = 1'b0; rd1 = 1'b0; wd1 = '0; ws1 = '0;
        wr0 = 1'b0; rd0 = 1'b0; wd0 = '0; ws0 = '0;
        repeat (2) @(negedge CLK);

        // Reset state
        chk("rst_count", 64'(cnt1), 64'd0);
        chk("rst_empty", 64'(empty1), 64'd1);
        chk("rst_full", 64'(full1), 64'd0);
        chk("rst_aempty", 64'(ae1), 64'd1);
        chk("rst_afull", 64'(af1), 64'd0);
        chk("rst_rdvalid", 64'(rv1), 64'd0);
        chk("rst_rddata", rdat1, 64'd0);
        chk("rst_std_rdvalid", 64'(rv0), 64'd0);
        chk("rst_std_empty", 64'(empty0), 64'd1);
        RESETN = 1'b1;
        @(negedge CLK);

        // Standard read mode vectors
        for (int i = 0; i < 11; i++) begin
            wr0 = tbl[i].wr; rd0 = tbl[i].rd; wd0 = tbl[i].d; ws0 = tbl[i].s;
            @(posedge CLK);
            @(negedge CLK);
            wr0 = 1'b0; rd0 = 1'b0;
            chk($sformatf("std%0d_count", i), 64'(cnt0), 64'(tbl[i].e_cnt));
            chk($sformatf("std%0d_empty", i), 64'(empty0), 64'(tbl[i].e_empty));
            chk($sformatf("std%0d_rdValid", i), 64'(rv0), 64'(tbl[i].e_rv));
            chk($sformatf("std%0d_underflow", i), 64'(uf0), 64'(tbl[i].e_uf));
            chk($sformatf("std%0d_aempty", i), 64'(ae0), 64'(tbl[i].e_ae));
            chk($sformatf("std%0d_rdData", i), rdat0, tbl[i].e_dat);
            chk($sformatf("std%0d_rdStrb", i), 64'(rstb0), 64'(tbl[i].e_strb));
        end

        // First write into empty FWFT FIFO: head appears two edges later
        step1(1'b1, 64'hA5A5_0000_0000_0001, 8'hFF, 1'b0);
        chk("first_empty_n", 64'(empty1), 64'd1);
        chk("first_count", 64'(cnt1), 64'd1);
        step1(1'b0, '0, '0, 1'b0);
        chk("first_empty_n1", 64'(empty1), 64'd1);
        step1(1'b0, '0, '0, 1'b0);
        chk("first_empty_n2", 64'(empty1), 64'd0);
        chk("first_data", rdat1, 64'hA5A5_0000_0000_0001);
        chk("first_strb", 64'(rstb1), 64'hFF);
        step1(1'b0, '0, '0, 1'b1);
        repeat (2) step1(1'b0, '0, '0, 1'b0);

        // Fill, overflow, gapless drain
        for (int i = 0; i < 16; i++) step1(1'b1, 64'(i), 8'(i), 1'b0);
        chk("fill_full", 64'(full1), 64'd1);
        repeat (3) step1(1'b0, '0, '0, 1'b0);
        step1(1'b1, 64'hBAD, 8'h11, 1'b0);
        chk("ovf_pulse", 64'(of1), 64'd1);
        chk("ovf_count", 64'(cnt1), 64'd16);
        step1(1'b0, '0, '0, 1'b0);
        chk("ovf_once", 64'(of1), 64'd0);
        for (int i = 0; i < 16; i++) begin
            chk("drain_nogap", 64'(empty1), 64'd0);
            chk("drain_value", rdat1, 64'(i));
            step1(1'b0, '0, '0, 1'b1);
        end
        chk("drain_count", 64'(cnt1), 64'd0);

        // Concurrent push/pop at count 8
        for (int i = 0; i < 8; i++) step1(1'b1, 64'(100 + i), 8'(i), 1'b0);
        repeat (3) step1(1'b0, '0, '0, 1'b0);
        for (int k = 0; k < 100; k++) begin
            chk("steady_ready", 64'(empty1), 64'd0);
            step1(1'b1, 64'(200 + k), 8'(k), 1'b1);
            chk("steady_count", 64'(cnt1), 64'd8);
        end
        for (int k = 0; k < 40 && mq.size() > 0; k++) step1(1'b0, '0, '0, 1'b1);

        // Random traffic, write-biased then read-biased
        for (int k = 0; k < 400; k++) begin
            logic w, r;
            int wb;
            wb = (k < 200) ? 70 : 35;
            w = ($urandom_range(0, 99) < wb);
            r = ($urandom_range(0, 99) < 50);
            step1(w, {$urandom, $urandom}, 8'($urandom), r);
        end
        for (int k = 0; k < 40 && mq.size() > 0; k++) step1(1'b0, '0, '0, 1'b1);

        // Asynchronous reset with 9 words held
        for (int i = 0; i < 9; i++) step1(1'b1, 64'(300 + i), 8'h0F, 1'b0);
        chk("prerst_count", 64'(cnt1), 64'd9);
        #3;
        RESETN = 1'b0;
        #1;
        chk("arst_count", 64'(cnt1), 64'd0);
        chk("arst_empty", 64'(empty1), 64'd1);
        chk("arst_full", 64'(full1), 64'd0);
        chk("arst_aempty", 64'(ae1), 64'd1);
        chk("arst_afull", 64'(af1), 64'd0);
        chk("arst_rddata", rdat1, 64'd0);
        mq.delete();
        @(negedge CLK);
        RESETN = 1'b1;
        step1(1'b0, '0, '0, 1'b0);
        chk("post_rst_empty", 64'(empty1), 64'd1);
        step1(1'b1, 64'h0123_4567_89AB_CDEF, 8'h5A, 1'b0);
        repeat (2) step1(1'b0, '0, '0, 1'b0);
        chk("post_rst_data", rdat1, 64'h0123_4567_89AB_CDEF);
        chk("post_rst_strb", 64'(rstb1), 64'h5A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
